lcd_rgb_capture: RTL

//  Parallel RGB (DE/HSYNC/VSYNC + RGB888) video receiver: the capture-side counterpart of the LCD output path.

---
 rtl/lcd_rgb_capture.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lcd_rgb_capture.sv
// rtl/lcd_rgb_capture.sv - parallel RGB888 video capture into an RGB565 display FIFO
// Measures line width / line count per frame, flags size mismatch and FIFO overflow.
module lcd_rgb_capture #(
  parameter int H_ACTIVE  = 800,
  parameter int V_ACTIVE  = 480,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        LCD_DE,
  input  logic        LCD_HSYNC,
  input  logic        LCD_VSYNC,
  input  logic [7:0]  LCD_R,
  input  logic [7:0]  LCD_G,
  input  logic [7:0]  LCD_B,
  input  logic        CAP_EN,
  input  logic        FIFO_FULL,
  output logic        FIFO_WE,
  output logic [15:0] FIFO_DATA,
  output logic        FRAME_START,
  output logic        FRAME_DONE,
  output logic [10:0] PIX_CNT,
  output logic [10:0] LINE_CNT,
  output logic        OVERFLOW,
  output logic        SIZE_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_ACTIVE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_frame_start;
  logic        w_frame_done;

  logic        r1_de, r1_vs, r2_de, r2_vs;
  logic [15:0] r1_pix;
  logic [10:0] r_pix_cnt;

  logic        w_vs_rise;
  logic        w_line_end;
  logic [10:0] w_pix_inc;
  logic [10:0] w_line_inc;
  logic [10:0] w_line_upd;
  logic        w_unused;

  // HSYNC and the colour LSBs dropped by RGB565 packing carry no information we use.
  assign w_unused = ^{LCD_HSYNC, LCD_R[2:0], LCD_G[1:0], LCD_B[2:0]};

  assign w_vs_rise  = (r1_vs == VSYNC_POL) && (r2_vs != VSYNC_POL);
  assign w_line_end = (r_state == S_ACTIVE) && !r1_de && r2_de;
  assign w_pix_inc  = (r_pix_cnt == 11'h7FF) ? r_pix_cnt : r_pix_cnt + 11'd1;
  assign w_line_inc = (LINE_CNT == 11'h7FF) ? LINE_CNT : LINE_CNT + 11'd1;
  assign w_line_upd = w_line_end ? w_line_inc : LINE_CNT;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r1_de  <= 1'b0;
      r1_vs  <= 1'b0;
      r1_pix <= '0;
      r2_de  <= 1'b0;
      r2_vs  <= 1'b0;
    end else begin
      r1_de  <= LCD_DE;
      r1_vs  <= LCD_VSYNC;
      r1_pix <= {LCD_R[7:3], LCD_G[7:2], LCD_B[7:3]};
      r2_de  <= r1_de;
      r2_vs  <= r1_vs;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    w_frame_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (CAP_EN) w_state_next = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (!CAP_EN) begin
          w_state_next = S_IDLE;
        end else if (w_vs_rise) begin
          w_state_next  = S_ACTIVE;
          w_frame_start = 1'b1;
        end
      end
      S_ACTIVE: begin
        // Dropping CAP_EN only takes effect at the frame boundary.
        if (w_vs_rise) begin
          w_frame_done = 1'b1;
          if (CAP_EN) w_frame_start = 1'b1;
          else        w_state_next  = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      FIFO_WE     <= 1'b0;
      FIFO_DATA   <= '0;
      FRAME_START <= 1'b0;
      FRAME_DONE  <= 1'b0;
      PIX_CNT     <= '0;
      LINE_CNT    <= '0;
      OVERFLOW    <= 1'b0;
      SIZE_ERR    <= 1'b0;
      r_pix_cnt   <= '0;
    end else begin
      FRAME_START <= w_frame_start;
      FRAME_DONE  <= w_frame_done;
      FIFO_WE     <= 1'b0;
      LINE_CNT    <= w_line_upd;
      if (r_state == S_ACTIVE && r1_de) begin
        r_pix_cnt <= w_pix_inc;
        if (!FIFO_FULL) begin
          FIFO_WE   <= 1'b1;
          FIFO_DATA <= r1_pix;
        end else begin
          OVERFLOW <= 1'b1;
        end
      end
      if (w_line_end) begin
        PIX_CNT   <= r_pix_cnt;
        r_pix_cnt <= '0;
        if (r_pix_cnt != 11'(H_ACTIVE)) SIZE_ERR <= 1'b1;
      end
      // Frame check sees a line that ends on the same cycle as the VSYNC edge.
      if (w_frame_done && (w_line_upd != 11'(V_ACTIVE))) SIZE_ERR <= 1'b1;
      if (w_frame_start) begin
        LINE_CNT  <= '0;
        r_pix_cnt <= '0;
      end
      if (r_state == S_IDLE) begin
        OVERFLOW <= 1'b0;
        SIZE_ERR <= 1'b0;
      end
    end
  end

endmodule
